// File: rtl/sram_rr_arbiter.sv
// sram_rr_arbiter: shares one single-port SRAM (1-cycle registered read,
// per-byte write enables) between NUM_PORTS valid/ready requesters using
// round-robin arbitration. Every accepted access gets a one-cycle response
// strobe on its port exactly one cycle after acceptance.
//
// Optional feature macro: SRAM_ARB_LOCK_EN
//   When defined, a port can hold the grant across accesses with req_lock_i.
//   When undefined, req_lock_i is ignored and no lock state exists.
module sram_rr_arbiter #(
  parameter int unsigned NUM_PORTS  = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_WORDS  = 1024,
  localparam int unsigned AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
  localparam int unsigned DW = DATA_WIDTH,
  localparam int unsigned BW = (DATA_WIDTH + 7) / 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_PORTS-1:0]    req_valid_i,
  output logic [NUM_PORTS-1:0]    req_ready_o,
  input  logic [NUM_PORTS-1:0]    req_we_i,
  input  logic [NUM_PORTS*AW-1:0] req_addr_i,
  input  logic [NUM_PORTS*DW-1:0] req_wdata_i,
  input  logic [NUM_PORTS*BW-1:0] req_be_i,
  input  logic [NUM_PORTS-1:0]    req_lock_i,
  output logic [NUM_PORTS-1:0]    rsp_valid_o,
  output logic [DW-1:0]           rsp_rdata_o,
  output logic                    sram_req_o,
  output logic                    sram_we_o,
  output logic [AW-1:0]           sram_addr_o,
  output logic [DW-1:0]           sram_wdata_o,
  output logic [BW-1:0]           sram_be_o,
  input  logic [DW-1:0]           sram_rdata_i
);

  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [PW-1:0]        rr_ptr_q;
  logic [PW-1:0]        grant_idx;
  logic                 grant_vld;
  logic                 lock_hold;
  logic [NUM_PORTS-1:0] rsp_valid_q;
  logic                 rd_pending_q;

  // Port index (base + off) wrapped into 0..NUM_PORTS-1.
  function automatic logic [PW-1:0] wrap_add(input int unsigned base, input int unsigned off);
    int unsigned sum;
    sum = base + off;
    if (sum >= NUM_PORTS) sum = sum - NUM_PORTS;
    return sum[PW-1:0];
  endfunction

`ifdef SRAM_ARB_LOCK_EN
  logic          lock_active_q;
  logic [PW-1:0] lock_owner_q;

  // A lock only matters while its owner keeps valid high; a dropped valid releases it.
  assign lock_hold = lock_active_q && req_valid_i[lock_owner_q];

  // While the lock holds, the owner is the grantee, so the next lock state is simply
  // the lock bit of whichever access is accepted this cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_active_q <= 1'b0;
      lock_owner_q  <= '0;
    end else begin
      lock_active_q <= grant_vld && req_lock_i[grant_idx];
      if (grant_vld && req_lock_i[grant_idx]) lock_owner_q <= grant_idx;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^req_lock_i;
  assign lock_hold   = 1'b0;
`endif

  // Round-robin search from rr_ptr upward; a held lock overrides the search.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    if (lock_hold) begin
      grant_vld = 1'b1;
      grant_idx = lock_owner_sel();
    end else begin
      for (int unsigned i = 0; i < NUM_PORTS; i++) begin
        if (!grant_vld && req_valid_i[wrap_add(32'(rr_ptr_q), i)]) begin
          grant_vld = 1'b1;
          grant_idx = wrap_add(32'(rr_ptr_q), i);
        end
      end
    end
    if (!rst_ni) grant_vld = 1'b0;
  end

  function automatic logic [PW-1:0] lock_owner_sel();
`ifdef SRAM_ARB_LOCK_EN
    return lock_owner_q;
`else
    return '0;
`endif
  endfunction

  // Steer the granted port's fields onto the SRAM; idle drives everything to 0.
  always_comb begin
    req_ready_o  = '0;
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_be_o    = '0;
    if (grant_vld) begin
      req_ready_o[grant_idx] = 1'b1;
      sram_req_o             = 1'b1;
      sram_we_o              = req_we_i[grant_idx];
      sram_addr_o            = req_addr_i[32'(grant_idx)*AW +: AW];
      sram_wdata_o           = req_wdata_i[32'(grant_idx)*DW +: DW];
      sram_be_o              = req_be_i[32'(grant_idx)*BW +: BW];
    end
  end

  // Pointer advance past the grantee (frozen under lock) and one-cycle response strobe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q     <= '0;
      rsp_valid_q  <= '0;
      rd_pending_q <= 1'b0;
    end else begin
      rsp_valid_q  <= '0;
      rd_pending_q <= 1'b0;
      if (grant_vld) begin
        rsp_valid_q[grant_idx] <= 1'b1;
        rd_pending_q           <= !req_we_i[grant_idx];
        if (!lock_hold) rr_ptr_q <= wrap_add(32'(grant_idx), 1);
      end
    end
  end

  // Read data comes straight from the SRAM's registered output in the response cycle.
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rd_pending_q ? sram_rdata_i : '0;

endmodule
